mem_kbd_mmio: RTL and testbench

Parametrised unified instruction/data memory for the keyboard-input CPU, with a memory-mapped keyboard scan-code FIFO. It has a byte-addressed instruction port and a data port with byte-enable writes. Both ports read synchronously with one-cycle latency. A small FIFO buffers simulated key presses and exposes them to software at a fixed MMIO base address, with an interrupt line.

---
 rtl/mem_pkg.sv | 37 +++
 rtl/kbd_fifo.sv | 76 +++++++
 rtl/mem_kbd_mmio.sv | 158 +++++++++++++++
 tb/tb_mem_kbd_mmio.sv | 228 ++++++++++++++++++++++
 4 files changed

// File: rtl/mem_pkg.sv
// mem_pkg: shared constants for the unified memory with keyboard MMIO.
//   - Register offsets within the keyboard block (KBD_DATA / KBD_STATUS).
//   - STATUS register bit positions.
//   - kbd_reg_e: register select decoded from address bit 2.
//   - kbd_status_word(): packs FIFO state into the STATUS read value.
package mem_pkg;

    localparam logic [2:0] KBD_DATA_OFS   = 3'd0;
    localparam logic [2:0] KBD_STATUS_OFS = 3'd4;

    localparam int ST_EMPTY     = 0;
    localparam int ST_FULL      = 1;
    localparam int ST_OVF       = 2;
    localparam int ST_COUNT_LSB = 8;

    // Address bit 2 picks the register: 0 -> KBD_DATA, 1 -> KBD_STATUS.
    typedef enum logic {
        KBD_REG_DATA   = KBD_DATA_OFS[2],
        KBD_REG_STATUS = KBD_STATUS_OFS[2]
    } kbd_reg_e;

    function automatic logic [31:0] kbd_status_word(
        input logic [23:0] count,
        input logic        ovf,
        input logic        full,
        input logic        empty
    );
        logic [31:0] w;
        w = '0;
        w[ST_COUNT_LSB +: 24] = count;
        w[ST_OVF]             = ovf;
        w[ST_FULL]            = full;
        w[ST_EMPTY]           = empty;
        return w;
    endfunction

endpackage

// File: rtl/kbd_fifo.sv
// kbd_fifo: scan-code FIFO with sticky overflow flag.
// Ports:
//   clk, rst_n      - clock, synchronous active-low reset (pointers, overflow)
//   push_i, data_i  - enqueue strobe and scan code
//   pop_i           - dequeue strobe (ignored when empty)
//   clear_ovf_i     - clears the sticky overflow flag
//   head_o          - oldest entry
//   full_o, empty_o - occupancy flags
//   count_o         - current occupancy
//   count_nxt_o     - occupancy after this edge (for registered irq)
//   overflow_o      - sticky: a push was dropped while full
module kbd_fifo
    import mem_pkg::*;
#(
    parameter int KBD_DEPTH = 8
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         push_i,
    input  logic [7:0]                   data_i,
    input  logic                         pop_i,
    input  logic                         clear_ovf_i,
    output logic [7:0]                   head_o,
    output logic                         full_o,
    output logic                         empty_o,
    output logic [$clog2(KBD_DEPTH):0]   count_o,
    output logic [$clog2(KBD_DEPTH):0]   count_nxt_o,
    output logic                         overflow_o
);

    localparam int PW = $clog2(KBD_DEPTH) + 1;

    logic [7:0]    buf_q [KBD_DEPTH];
    logic [PW-1:0] wptr_q, wptr_d;
    logic [PW-1:0] rptr_q, rptr_d;
    logic          ovf_q, ovf_d;
    logic          do_push, do_pop, ovf_set;

    // Extra pointer MSB distinguishes full from empty when indices match.
    assign empty_o = (wptr_q == rptr_q);
    assign full_o  = (wptr_q[PW-1] != rptr_q[PW-1]) &&
                     (wptr_q[PW-2:0] == rptr_q[PW-2:0]);

    assign do_pop  = pop_i && !empty_o;
    // A pop on the same edge frees a slot, so a full FIFO still accepts.
    assign do_push = push_i && (!full_o || do_pop);
    assign ovf_set = push_i && full_o && !do_pop;

    assign wptr_d = wptr_q + PW'(do_push);
    assign rptr_d = rptr_q + PW'(do_pop);
    assign ovf_d  = (ovf_q && !clear_ovf_i) || ovf_set;

    assign head_o      = buf_q[rptr_q[PW-2:0]];
    assign count_o     = wptr_q - rptr_q;
    assign count_nxt_o = wptr_d - rptr_d;
    assign overflow_o  = ovf_q;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wptr_q <= '0;
            rptr_q <= '0;
            ovf_q  <= 1'b0;
        end else begin
            wptr_q <= wptr_d;
            rptr_q <= rptr_d;
            ovf_q  <= ovf_d;
        end
    end

    always_ff @(posedge clk) begin
        if (rst_n && do_push) begin
            buf_q[wptr_q[PW-2:0]] <= data_i;
        end
    end

endmodule

// File: rtl/mem_kbd_mmio.sv
// mem_kbd_mmio: unified instruction/data RAM with a memory-mapped keyboard FIFO.
// Ports:
//   clk, rst_n          - clock, synchronous active-low reset
//   PC / instruction    - instruction byte address / registered word (1-cycle)
//   data_addr, data_in  - data byte address, write data
//   wr_en, rd_en        - data write / read strobes
//   byte_en             - write lane enables (bit i -> data_in[8i+7:8i])
//   data_out            - registered data-port result (holds when idle)
//   kbd_valid, kbd_code - scan-code push strobe and value
//   kbd_ready           - FIFO can accept a code
//   kbd_irq             - registered FIFO non-empty
// The keyboard block lives at KBD_BASE: +0 KBD_DATA (read pops), +4 KBD_STATUS.
module mem_kbd_mmio
    import mem_pkg::*;
#(
    parameter int          DEPTH_WORDS = 1024,
    parameter int          KBD_DEPTH   = 8,
    parameter logic [31:0] KBD_BASE    = 32'hFFFF_0000
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [31:0] PC,
    output logic [31:0] instruction,
    input  logic [31:0] data_addr,
    input  logic [31:0] data_in,
    input  logic        wr_en,
    input  logic        rd_en,
    input  logic [3:0]  byte_en,
    output logic [31:0] data_out,
    input  logic        kbd_valid,
    input  logic [7:0]  kbd_code,
    output logic        kbd_ready,
    output logic        kbd_irq
);

    localparam int AW = $clog2(DEPTH_WORDS);
    localparam int CW = $clog2(KBD_DEPTH) + 1;

    logic [31:0]   mem [DEPTH_WORDS];

    logic [AW-1:0] d_idx, i_idx;
    logic          d_mmio, i_mmio;
    kbd_reg_e      d_reg;
    logic [31:0]   ram_word, merged_word;
    logic          ram_we;

    logic [31:0]   data_out_q, data_out_d;
    logic [31:0]   instr_q, instr_d;
    logic          irq_q;

    logic          fifo_push, fifo_pop, fifo_clr_ovf;
    logic [7:0]    fifo_head;
    logic          fifo_full, fifo_empty, fifo_ovf;
    logic [CW-1:0] fifo_count, fifo_count_nxt;
    logic [31:0]   status_word;

    logic          unused_addr_bits;
    assign unused_addr_bits = ^{data_addr[1:0], PC[1:0]};

    // Upper address bits beyond the RAM size alias; MMIO match takes priority.
    assign d_idx  = data_addr[AW+1:2];
    assign i_idx  = PC[AW+1:2];
    assign d_mmio = (data_addr[31:3] == KBD_BASE[31:3]);
    assign i_mmio = (PC[31:3] == KBD_BASE[31:3]);
    assign d_reg  = kbd_reg_e'(data_addr[2]);

    assign ram_word = mem[d_idx];
    assign ram_we   = rst_n && wr_en && !d_mmio;

    always_comb begin
        merged_word = ram_word;
        for (int i = 0; i < 4; i++) begin
            if (byte_en[i]) begin
                merged_word[8*i +: 8] = data_in[8*i +: 8];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (ram_we) begin
            for (int i = 0; i < 4; i++) begin
                if (byte_en[i]) begin
                    mem[d_idx][8*i +: 8] <= data_in[8*i +: 8];
                end
            end
        end
    end

    // Write has priority over read for side effects: no pop when wr_en is set.
    assign fifo_push    = rst_n && kbd_valid;
    assign fifo_pop     = rst_n && rd_en && !wr_en && d_mmio && (d_reg == KBD_REG_DATA);
    assign fifo_clr_ovf = rst_n && wr_en && d_mmio && (d_reg == KBD_REG_STATUS) &&
                          data_in[ST_OVF];

    kbd_fifo #(
        .KBD_DEPTH (KBD_DEPTH)
    ) u_fifo (
        .clk         (clk),
        .rst_n       (rst_n),
        .push_i      (fifo_push),
        .data_i      (kbd_code),
        .pop_i       (fifo_pop),
        .clear_ovf_i (fifo_clr_ovf),
        .head_o      (fifo_head),
        .full_o      (fifo_full),
        .empty_o     (fifo_empty),
        .count_o     (fifo_count),
        .count_nxt_o (fifo_count_nxt),
        .overflow_o  (fifo_ovf)
    );

    assign status_word = kbd_status_word(24'(fifo_count), fifo_ovf, fifo_full, fifo_empty);

    always_comb begin
        data_out_d = data_out_q;
        if (wr_en || rd_en) begin
            if (d_mmio) begin
                if (d_reg == KBD_REG_STATUS) begin
                    data_out_d = status_word;
                end else if (wr_en || fifo_empty) begin
                    data_out_d = '0;
                end else begin
                    data_out_d = {24'b0, fifo_head};
                end
            end else begin
                data_out_d = wr_en ? merged_word : ram_word;
            end
        end
    end

    // Instruction fetch sees a same-edge data write to its word (write-first).
    always_comb begin
        instr_d = mem[i_idx];
        if (i_mmio) begin
            instr_d = '0;
        end else if (ram_we && (i_idx == d_idx)) begin
            instr_d = merged_word;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            data_out_q <= '0;
            instr_q    <= '0;
            irq_q      <= 1'b0;
        end else begin
            data_out_q <= data_out_d;
            instr_q    <= instr_d;
            irq_q      <= (fifo_count_nxt != '0);
        end
    end

    assign data_out    = data_out_q;
    assign instruction = instr_q;
    assign kbd_irq     = irq_q;
    assign kbd_ready   = !fifo_full && rst_n;

endmodule

// File: tb/tb_mem_kbd_mmio.sv
// Directed testbench for mem_kbd_mmio with default parameters.
module tb_mem_kbd_mmio;

    localparam logic [31:0] KBD_BASE = 32'hFFFF_0000;
    localparam logic [31:0] KDATA    = KBD_BASE;
    localparam logic [31:0] KSTAT    = KBD_BASE + 32'd4;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [31:0] PC;
    logic [31:0] instruction;
    logic [31:0] data_addr;
    logic [31:0] data_in;
    logic        wr_en;
    logic        rd_en;
    logic [3:0]  byte_en;
    logic [31:0] data_out;
    logic        kbd_valid;
    logic [7:0]  kbd_code;
    logic        kbd_ready;
    logic        kbd_irq;

    int total_cnt = 0;
    int pass_cnt  = 0;

    mem_kbd_mmio #(
        .DEPTH_WORDS (1024),
        .KBD_DEPTH   (8),
        .KBD_BASE    (KBD_BASE)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .PC          (PC),
        .instruction (instruction),
        .data_addr   (data_addr),
        .data_in     (data_in),
        .wr_en       (wr_en),
        .rd_en       (rd_en),
        .byte_en     (byte_en),
        .data_out    (data_out),
        .kbd_valid   (kbd_valid),
        .kbd_code    (kbd_code),
        .kbd_ready   (kbd_ready),
        .kbd_irq     (kbd_irq)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        wr_en     = 1'b0;
        rd_en     = 1'b0;
        kbd_valid = 1'b0;
        byte_en   = 4'h0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; PC = 32'h0; data_addr = 32'h0; data_in = 32'h0;
        kbd_code = 8'h0; idle();
        tick(); tick();
        total_cnt++; if (data_out !== 32'h0) $display("FAIL rst_data_out got=%h exp=0", data_out); else pass_cnt++;
        total_cnt++; if (instruction !== 32'h0) $display("FAIL rst_instruction got=%h exp=0", instruction); else pass_cnt++;
        total_cnt++; if (kbd_irq !== 1'b0) $display("FAIL rst_irq got=%b exp=0", kbd_irq); else pass_cnt++;
        total_cnt++; if (kbd_ready !== 1'b0) $display("FAIL rst_ready_low got=%b exp=0", kbd_ready); else pass_cnt++;
        rst_n = 1'b1;
        tick();
        total_cnt++; if (kbd_ready !== 1'b1) $display("FAIL rst_ready_high got=%b exp=1", kbd_ready); else pass_cnt++;
        total_cnt++; if (kbd_irq !== 1'b0) $display("FAIL rst_irq_after got=%b exp=0", kbd_irq); else pass_cnt++;
    endtask

    task automatic test_word_rw();
        data_addr = 32'd8; data_in = 32'h1; byte_en = 4'hF; wr_en = 1'b1;
        tick();
        total_cnt++; if (data_out !== 32'h1) $display("FAIL word_write_first got=%h exp=1", data_out); else pass_cnt++;
        idle(); PC = 32'd8;
        tick();
        total_cnt++; if (instruction !== 32'h1) $display("FAIL word_ifetch got=%h exp=1", instruction); else pass_cnt++;
        // Same-edge write and fetch of one word
        data_addr = 32'd16; data_in = 32'h1234_5678; byte_en = 4'hF; wr_en = 1'b1; PC = 32'd16;
        tick();
        total_cnt++; if (instruction !== 32'h1234_5678) $display("FAIL ifetch_bypass got=%h exp=12345678", instruction); else pass_cnt++;
        total_cnt++; if (data_out !== 32'h1234_5678) $display("FAIL data_bypass got=%h exp=12345678", data_out); else pass_cnt++;
        idle(); PC = KBD_BASE;
        tick();
        total_cnt++; if (instruction !== 32'h0) $display("FAIL ifetch_mmio got=%h exp=0", instruction); else pass_cnt++;
    endtask

    task automatic test_byte_lanes();
        data_addr = 32'd12; data_in = 32'hAABB_CCDD; byte_en = 4'hF; wr_en = 1'b1;
        tick();
        data_in = 32'h1122_3344; byte_en = 4'b0101;
        tick();
        total_cnt++; if (data_out !== 32'hAA22_CC44) $display("FAIL lane_merge got=%h exp=aa22cc44", data_out); else pass_cnt++;
        data_in = 32'hFFFF_FFFF; byte_en = 4'h0;
        tick();
        total_cnt++; if (data_out !== 32'hAA22_CC44) $display("FAIL lane_none got=%h exp=aa22cc44", data_out); else pass_cnt++;
        idle(); rd_en = 1'b1; data_addr = 32'd12 + 32'd4096 + 32'd3;
        tick();
        total_cnt++; if (data_out !== 32'hAA22_CC44) $display("FAIL alias_read got=%h exp=aa22cc44", data_out); else pass_cnt++;
        idle(); data_addr = 32'd8;
        tick();
        total_cnt++; if (data_out !== 32'hAA22_CC44) $display("FAIL idle_hold got=%h exp=aa22cc44", data_out); else pass_cnt++;
    endtask

    task automatic test_fifo_order();
        kbd_valid = 1'b1; kbd_code = 8'h1C;
        tick();
        total_cnt++; if (kbd_irq !== 1'b1) $display("FAIL irq_rise got=%b exp=1", kbd_irq); else pass_cnt++;
        kbd_code = 8'h32;
        tick();
        idle(); rd_en = 1'b1; data_addr = KSTAT;
        tick();
        total_cnt++; if (data_out !== 32'h0000_0200) $display("FAIL status_two got=%h exp=00000200", data_out); else pass_cnt++;
        data_addr = KDATA;
        tick();
        total_cnt++; if (data_out !== 32'h1C) $display("FAIL pop_first got=%h exp=1c", data_out); else pass_cnt++;
        total_cnt++; if (kbd_irq !== 1'b1) $display("FAIL irq_one_left got=%b exp=1", kbd_irq); else pass_cnt++;
        tick();
        total_cnt++; if (data_out !== 32'h32) $display("FAIL pop_second got=%h exp=32", data_out); else pass_cnt++;
        total_cnt++; if (kbd_irq !== 1'b0) $display("FAIL irq_fall got=%b exp=0", kbd_irq); else pass_cnt++;
        tick();
        total_cnt++; if (data_out !== 32'h0) $display("FAIL pop_empty got=%h exp=0", data_out); else pass_cnt++;
        data_addr = KSTAT;
        tick();
        total_cnt++; if (data_out !== 32'h0000_0001) $display("FAIL status_empty got=%h exp=00000001", data_out); else pass_cnt++;
        idle();
    endtask

    task automatic test_overflow();
        for (int i = 0; i < 9; i++) begin
            kbd_valid = 1'b1; kbd_code = 8'h10 + 8'(i);
            tick();
            if (i == 7) begin
                total_cnt++; if (kbd_ready !== 1'b0) $display("FAIL ready_full got=%b exp=0", kbd_ready); else pass_cnt++;
            end
        end
        idle(); rd_en = 1'b1; data_addr = KSTAT;
        tick();
        total_cnt++; if (data_out !== 32'h0000_0806) $display("FAIL status_ovf got=%h exp=00000806", data_out); else pass_cnt++;
        idle(); wr_en = 1'b1; data_in = 32'h4;
        tick();
        idle(); rd_en = 1'b1;
        tick();
        total_cnt++; if (data_out !== 32'h0000_0802) $display("FAIL status_clr got=%h exp=00000802", data_out); else pass_cnt++;
        idle();
    endtask

    task automatic test_push_pop_full();
        logic [7:0] exp_q [8];
        for (int i = 0; i < 7; i++) exp_q[i] = 8'h11 + 8'(i);
        exp_q[7] = 8'h55;
        kbd_valid = 1'b1; kbd_code = 8'h55; rd_en = 1'b1; data_addr = KDATA;
        tick();
        total_cnt++; if (data_out !== 32'h10) $display("FAIL full_pp_head got=%h exp=10", data_out); else pass_cnt++;
        idle(); rd_en = 1'b1; data_addr = KSTAT;
        tick();
        total_cnt++; if (data_out !== 32'h0000_0802) $display("FAIL full_pp_status got=%h exp=00000802", data_out); else pass_cnt++;
        data_addr = KDATA;
        for (int i = 0; i < 8; i++) begin
            tick();
            total_cnt++; if (data_out !== {24'b0, exp_q[i]}) $display("FAIL drain_%0d got=%h exp=%h", i, data_out, exp_q[i]); else pass_cnt++;
        end
        data_addr = KSTAT;
        tick();
        total_cnt++; if (data_out !== 32'h0000_0001) $display("FAIL drained_status got=%h exp=00000001", data_out); else pass_cnt++;
        idle();
    endtask

    task automatic test_empty_push_pop();
        kbd_valid = 1'b1; kbd_code = 8'h77; rd_en = 1'b1; data_addr = KDATA;
        tick();
        total_cnt++; if (data_out !== 32'h0) $display("FAIL empty_pp_data got=%h exp=0", data_out); else pass_cnt++;
        total_cnt++; if (kbd_irq !== 1'b1) $display("FAIL empty_pp_irq got=%b exp=1", kbd_irq); else pass_cnt++;
        idle(); rd_en = 1'b1; data_addr = KSTAT;
        tick();
        total_cnt++; if (data_out !== 32'h0000_0100) $display("FAIL empty_pp_status got=%h exp=00000100", data_out); else pass_cnt++;
        // Read+write on KBD_DATA: write wins, no pop
        wr_en = 1'b1; data_addr = KDATA; data_in = 32'h0;
        tick();
        idle(); rd_en = 1'b1; data_addr = KDATA;
        tick();
        total_cnt++; if (data_out !== 32'h77) $display("FAIL rw_no_pop got=%h exp=77", data_out); else pass_cnt++;
        idle();
    endtask

    task automatic test_mid_reset();
        kbd_valid = 1'b1; kbd_code = 8'hAA;
        tick();
        kbd_code = 8'hBB;
        tick();
        idle();
        rst_n = 1'b0; wr_en = 1'b1; data_addr = 32'd8; data_in = 32'hDEAD_BEEF; byte_en = 4'hF;
        kbd_valid = 1'b1; kbd_code = 8'hCC; PC = 32'd12;
        tick();
        total_cnt++; if (data_out !== 32'h0) $display("FAIL mrst_data_out got=%h exp=0", data_out); else pass_cnt++;
        total_cnt++; if (instruction !== 32'h0) $display("FAIL mrst_instruction got=%h exp=0", instruction); else pass_cnt++;
        total_cnt++; if (kbd_irq !== 1'b0) $display("FAIL mrst_irq got=%b exp=0", kbd_irq); else pass_cnt++;
        rst_n = 1'b1; idle(); rd_en = 1'b1; data_addr = KSTAT;
        tick();
        total_cnt++; if (data_out !== 32'h0000_0001) $display("FAIL mrst_status got=%h exp=00000001", data_out); else pass_cnt++;
        total_cnt++; if (instruction !== 32'hAA22_CC44) $display("FAIL mrst_ifetch got=%h exp=aa22cc44", instruction); else pass_cnt++;
        data_addr = 32'd8;
        tick();
        total_cnt++; if (data_out !== 32'h1) $display("FAIL mrst_ram_kept got=%h exp=1", data_out); else pass_cnt++;
        data_addr = KDATA;
        tick();
        total_cnt++; if (data_out !== 32'h0) $display("FAIL mrst_pop_empty got=%h exp=0", data_out); else pass_cnt++;
        idle();
    endtask

    initial begin
        test_reset();
        test_word_rw();
        test_byte_lanes();
        test_fifo_order();
        test_overflow();
        test_push_pop_full();
        test_empty_push_pop();
        test_mid_reset();
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
